// File: rtl/bcd_stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// Module      : bcd_stopwatch_ctrl
// Description : Controller for a 3-digit BCD stopwatch / countdown timer. It
//               runs a prescaled tick and a start/stop/clear state machine,
//               and handles preset load, lap capture and terminal count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 10
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] pre2,
    input  logic [3:0] pre1,
    input  logic [3:0] pre0,
    input  logic       lap,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic [3:0] lap2,
    output logic [3:0] lap1,
    output logic [3:0] lap0,
    output logic       running,
    output logic       done,
    output logic [1:0] state
);

    localparam int              c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRESC_ONE = c_PW'(1);
    localparam logic [11:0]     c_TERM_UP   = 12'h999;
    localparam logic [11:0]     c_TERM_DN   = 12'h000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [11:0]     r_cnt_q,   w_cnt_d;
    logic [11:0]     r_lap_q,   w_lap_d;
    logic [c_PW-1:0] r_presc_q, w_presc_d;
    logic            r_dir_q,   w_dir_d;
    logic            r_run_q,   w_run_d;
    logic            r_done_q,  w_done_d;

    logic [11:0]     w_cnt_next;
    logic [11:0]     w_term_run;
    logic [11:0]     w_term_start;
    logic            w_tick;

    // One BCD step up or down, each digit wrapping within 0-9 with carry/borrow.
    function automatic logic [11:0] bcd_step(input logic [11:0] v, input logic down);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        h = v[11:8];
        t = v[7:4];
        u = v[3:0];
        if (!down) begin
            if (u >= 4'd9) begin
                u = 4'd0;
                if (t >= 4'd9) begin
                    t = 4'd0;
                    h = (h >= 4'd9) ? 4'd0 : h + 4'd1;
                end else begin
                    t = t + 4'd1;
                end
            end else begin
                u = u + 4'd1;
            end
        end else begin
            if (u == 4'd0) begin
                u = 4'd9;
                if (t == 4'd0) begin
                    t = 4'd9;
                    h = (h == 4'd0) ? 4'd9 : h - 4'd1;
                end else begin
                    t = t - 4'd1;
                end
            end else begin
                u = u - 4'd1;
            end
        end
        return {h, t, u};
    endfunction

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign w_cnt_next   = bcd_step(r_cnt_q, r_dir_q);
    assign w_term_run   = r_dir_q ? c_TERM_DN : c_TERM_UP;
    assign w_term_start = dir     ? c_TERM_DN : c_TERM_UP;
    assign w_tick       = (r_state_q == S_RUN) && (r_presc_q == c_PRESC_MAX);

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_lap_d   = r_lap_q;
        w_presc_d = r_presc_q;
        w_dir_d   = r_dir_q;

        // Lap samples the count as it stood before any same-cycle tick.
        if (lap && ((r_state_q == S_RUN) || (r_state_q == S_PAUSE))) begin
            w_lap_d = r_cnt_q;
        end

        case (r_state_q)
            S_IDLE: begin
                if (clr) begin
                    w_cnt_d   = 12'h000;
                    w_presc_d = '0;
                end else if (!stop && start) begin
                    if (r_cnt_q != w_term_start) begin
                        w_dir_d   = dir;
                        w_presc_d = '0;
                        w_state_d = S_RUN;
                    end
                end else if (!stop && load) begin
                    w_cnt_d = {clamp9(pre2), clamp9(pre1), clamp9(pre0)};
                end
            end
            S_RUN: begin
                if (clr) begin
                    w_cnt_d   = 12'h000;
                    w_presc_d = '0;
                    w_state_d = S_IDLE;
                end else if (stop) begin
                    // Pausing wins over a coincident tick; prescaler keeps its phase.
                    w_state_d = S_PAUSE;
                end else if (w_tick) begin
                    w_presc_d = '0;
                    w_cnt_d   = w_cnt_next;
                    if (w_cnt_next == w_term_run) begin
                        w_state_d = S_DONE;
                    end
                end else begin
                    w_presc_d = r_presc_q + c_PRESC_ONE;
                end
            end
            S_PAUSE: begin
                if (clr) begin
                    w_cnt_d   = 12'h000;
                    w_presc_d = '0;
                    w_state_d = S_IDLE;
                end else if (!stop && start) begin
                    w_state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (clr) begin
                    w_cnt_d   = 12'h000;
                    w_presc_d = '0;
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_run_d  = (w_state_d == S_RUN);
        w_done_d = (w_state_d == S_DONE) && (r_state_q != S_DONE);
    end

    always_ff @(posedge ck) begin
        if (rs) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= 12'h000;
            r_lap_q   <= 12'h000;
            r_presc_q <= '0;
            r_dir_q   <= 1'b0;
            r_run_q   <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_lap_q   <= w_lap_d;
            r_presc_q <= w_presc_d;
            r_dir_q   <= w_dir_d;
            r_run_q   <= w_run_d;
            r_done_q  <= w_done_d;
        end
    end

    assign bcd2    = r_cnt_q[11:8];
    assign bcd1    = r_cnt_q[7:4];
    assign bcd0    = r_cnt_q[3:0];
    assign lap2    = r_lap_q[11:8];
    assign lap1    = r_lap_q[7:4];
    assign lap0    = r_lap_q[3:0];
    assign running = r_run_q;
    assign done    = r_done_q;
    assign state   = r_state_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_stopwatch_ctrl
// Description : Scoreboard bench for bcd_stopwatch_ctrl with TICK_DIV = 4.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_stopwatch_ctrl;

    localparam int         c_TICK_DIV = 4;
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_RUN      = 2'd1;
    localparam logic [1:0] c_PAUSE    = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    logic       ck = 1'b0;
    logic       rs, start, stop, clr, dir, load, lap;
    logic [3:0] pre2, pre1, pre0;
    logic [3:0] bcd2, bcd1, bcd0;
    logic [3:0] lap2, lap1, lap0;
    logic       running, done;
    logic [1:0] state;

    bcd_stopwatch_ctrl #(.TICK_DIV(c_TICK_DIV)) u_dut (
        .ck      (ck),
        .rs      (rs),
        .start   (start),
        .stop    (stop),
        .clr     (clr),
        .dir     (dir),
        .load    (load),
        .pre2    (pre2),
        .pre1    (pre1),
        .pre0    (pre0),
        .lap     (lap),
        .bcd2    (bcd2),
        .bcd1    (bcd1),
        .bcd0    (bcd0),
        .lap2    (lap2),
        .lap1    (lap1),
        .lap0    (lap0),
        .running (running),
        .done    (done),
        .state   (state)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    typedef struct {
        int          tgt;
        logic [1:0]  st;
        logic [11:0] bcd;
        logic [11:0] lp;
        logic        run;
        logic        dn;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    exp_t        m_e;
    string       m_nm;
    logic [11:0] m_bcd;
    logic [11:0] m_lap;

    // Monitor: pops every expectation due at this cycle and compares.
    always @(negedge ck) begin
        #1;
        while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
            m_e   = exp_q.pop_front();
            m_nm  = name_q.pop_front();
            m_bcd = {bcd2, bcd1, bcd0};
            m_lap = {lap2, lap1, lap0};
            n_tests++;
            if (m_e.tgt != cyc || state !== m_e.st || m_bcd !== m_e.bcd ||
                m_lap !== m_e.lp || running !== m_e.run || done !== m_e.dn) begin
                n_fail++;
                $display("FAIL %s @cyc %0d (due %0d): got state=%0d bcd=%03h lap=%03h running=%0b done=%0b, want state=%0d bcd=%03h lap=%03h running=%0b done=%0b",
                         m_nm, cyc, m_e.tgt, state, m_bcd, m_lap, running, done,
                         m_e.st, m_e.bcd, m_e.lp, m_e.run, m_e.dn);
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic pulse(input logic s_start, input logic s_stop, input logic s_clr,
                         input logic s_load, input logic s_lap);
        start = s_start;
        stop  = s_stop;
        clr   = s_clr;
        load  = s_load;
        lap   = s_lap;
        @(negedge ck);
        start = 1'b0;
        stop  = 1'b0;
        clr   = 1'b0;
        load  = 1'b0;
        lap   = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [1:0] st, input logic [11:0] b,
                       input logic [11:0] l, input logic r, input logic d);
        exp_t e;
        e.tgt = cyc;
        e.st  = st;
        e.bcd = b;
        e.lp  = l;
        e.run = r;
        e.dn  = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic set_pre(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        pre2 = h;
        pre1 = t;
        pre0 = u;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rs = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;
        dir = 1'b0; load = 1'b0; lap = 1'b0;
        set_pre(4'd0, 4'd0, 4'd0);
        adv(2);
        rs = 1'b0;
        chk("reset", c_IDLE, 12'h000, 12'h000, 1'b0, 1'b0);

        // Count up with carry
        pulse(1, 0, 0, 0, 0);
        chk("start", c_RUN, 12'h000, 12'h000, 1'b1, 1'b0);
        adv(16);
        chk("up_4ticks", c_RUN, 12'h004, 12'h000, 1'b1, 1'b0);
        adv(144);
        chk("up_40ticks", c_RUN, 12'h040, 12'h000, 1'b1, 1'b0);
        pulse(0, 0, 1, 0, 0);
        chk("clr_run", c_IDLE, 12'h000, 12'h000, 1'b0, 1'b0);

        // Up to terminal 999
        set_pre(4'd9, 4'd9, 4'd7);
        pulse(0, 0, 0, 1, 0);
        chk("load_997", c_IDLE, 12'h997, 12'h000, 1'b0, 1'b0);
        pulse(1, 0, 0, 0, 0);
        chk("start_997", c_RUN, 12'h997, 12'h000, 1'b1, 1'b0);
        adv(7);
        chk("up_998", c_RUN, 12'h998, 12'h000, 1'b1, 1'b0);
        adv(1);
        chk("done_entry", c_DONE, 12'h999, 12'h000, 1'b0, 1'b1);
        adv(1);
        chk("done_pulse_end", c_DONE, 12'h999, 12'h000, 1'b0, 1'b0);
        set_pre(4'd1, 4'd2, 4'd3);
        pulse(1, 0, 0, 1, 1);
        chk("done_ignores", c_DONE, 12'h999, 12'h000, 1'b0, 1'b0);
        adv(19);
        chk("done_hold", c_DONE, 12'h999, 12'h000, 1'b0, 1'b0);
        pulse(0, 0, 1, 0, 0);
        chk("done_clr", c_IDLE, 12'h000, 12'h000, 1'b0, 1'b0);

        // Count down with borrow; dir change while running has no effect
        set_pre(4'd1, 4'd0, 4'd0);
        dir = 1'b1;
        pulse(0, 0, 0, 1, 0);
        chk("load_100", c_IDLE, 12'h100, 12'h000, 1'b0, 1'b0);
        pulse(1, 0, 0, 0, 0);
        adv(4);
        chk("down_borrow", c_RUN, 12'h099, 12'h000, 1'b1, 1'b0);
        dir = 1'b0;
        adv(4);
        chk("dir_ignored", c_RUN, 12'h098, 12'h000, 1'b1, 1'b0);
        pulse(0, 0, 1, 0, 0);
        dir = 1'b1;
        set_pre(4'd0, 4'd0, 4'd1);
        pulse(0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0);
        adv(4);
        chk("down_done", c_DONE, 12'h000, 12'h000, 1'b0, 1'b1);
        pulse(0, 0, 1, 0, 0);
        dir = 1'b0;

        // Pause keeps prescaler phase
        pulse(1, 0, 0, 0, 0);
        adv(2);
        pulse(0, 1, 0, 0, 0);
        chk("pause", c_PAUSE, 12'h000, 12'h000, 1'b0, 1'b0);
        adv(5);
        chk("pause_hold", c_PAUSE, 12'h000, 12'h000, 1'b0, 1'b0);
        pulse(1, 0, 0, 0, 0);
        chk("resume", c_RUN, 12'h000, 12'h000, 1'b1, 1'b0);
        adv(1);
        chk("resume_mid", c_RUN, 12'h000, 12'h000, 1'b1, 1'b0);
        adv(1);
        chk("resume_partial", c_RUN, 12'h001, 12'h000, 1'b1, 1'b0);
        adv(3);
        pulse(0, 1, 0, 0, 0);
        chk("stop_no_tick", c_PAUSE, 12'h001, 12'h000, 1'b0, 1'b0);
        pulse(1, 0, 0, 0, 0);
        chk("resume2", c_RUN, 12'h001, 12'h000, 1'b1, 1'b0);
        pulse(1, 1, 0, 0, 0);
        chk("start_stop", c_PAUSE, 12'h001, 12'h000, 1'b0, 1'b0);
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 1, 0, 0);
        chk("clr_stop", c_IDLE, 12'h000, 12'h000, 1'b0, 1'b0);

        // Lap capture
        set_pre(4'd0, 4'd1, 4'd2);
        pulse(0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0);
        adv(3);
        pulse(0, 0, 0, 0, 1);
        chk("lap_tick", c_RUN, 12'h013, 12'h012, 1'b1, 1'b0);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 1);
        chk("lap_pause", c_PAUSE, 12'h013, 12'h013, 1'b0, 1'b0);
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 1);
        chk("lap_idle_ignored", c_IDLE, 12'h000, 12'h013, 1'b0, 1'b0);

        // Clamping, start at terminal, reset mid-run
        set_pre(4'hF, 4'h3, 4'hA);
        pulse(0, 0, 0, 1, 0);
        chk("load_clamp", c_IDLE, 12'h939, 12'h013, 1'b0, 1'b0);
        pulse(0, 0, 1, 0, 0);
        dir = 1'b1;
        pulse(1, 0, 0, 0, 0);
        chk("start_at_term", c_IDLE, 12'h000, 12'h013, 1'b0, 1'b0);
        dir = 1'b0;
        pulse(1, 0, 0, 0, 0);
        adv(5);
        chk("pre_reset_run", c_RUN, 12'h001, 12'h013, 1'b1, 1'b0);
        rs = 1'b1;
        adv(1);
        rs = 1'b0;
        chk("reset_mid_run", c_IDLE, 12'h000, 12'h000, 1'b0, 1'b0);
        adv(4);
        chk("post_reset_idle", c_IDLE, 12'h000, 12'h000, 1'b0, 1'b0);

        adv(2);
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
            n_fail += exp_q.size();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
